// File: rtl/lpc_uart_framer_pkg.sv
// Shared constants and types for the LPC-record-to-UART framer.
package lpc_uart_framer_pkg;

  // Record field widths; a record is {cyctype, dir, addr, data}.
  localparam int unsigned CycTypeW = 3;
  localparam int unsigned AddrW    = 32;
  localparam int unsigned DataW    = 8;
  localparam int unsigned RecW     = CycTypeW + 1 + AddrW + DataW;

  // Frame layout: one sync byte, one header byte, four address bytes, one data byte.
  localparam int unsigned FrameLen  = 7;
  localparam logic [2:0]  ByteSync  = 3'd0;
  localparam logic [2:0]  ByteHdr   = 3'd1;
  localparam logic [2:0]  ByteAddr3 = 3'd2;
  localparam logic [2:0]  ByteAddr2 = 3'd3;
  localparam logic [2:0]  ByteAddr1 = 3'd4;
  localparam logic [2:0]  ByteAddr0 = 3'd5;
  localparam logic [2:0]  ByteData  = 3'(FrameLen - 1);

  // Framer FSM encoding.
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StSend    = 2'd1;
  localparam logic [1:0] StStrobe  = 2'd2;
  localparam logic [1:0] StWaitAck = 2'd3;

  typedef struct packed {
    logic [CycTypeW-1:0] cyctype;
    logic                dir;
    logic [AddrW-1:0]    addr;
    logic [DataW-1:0]    data;
  } lpc_rec_t;

  // Select one byte of the outgoing frame for a buffered record.
  function automatic logic [7:0] frame_byte(lpc_rec_t   rec,
                                            logic       lost,
                                            logic [2:0] idx,
                                            logic [7:0] sync);
    logic [7:0] b;
    case (idx)
      ByteSync:  b = sync;
      ByteHdr:   b = {lost, 3'b000, rec.dir, rec.cyctype};
      ByteAddr3: b = rec.addr[31:24];
      ByteAddr2: b = rec.addr[23:16];
      ByteAddr1: b = rec.addr[15:8];
      ByteAddr0: b = rec.addr[7:0];
      ByteData:  b = rec.data;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lpc_uart_framer_if.sv
// Record input, UART transmitter handshake and status signals of the framer.
interface lpc_uart_framer_if #(
  parameter int unsigned FIFO_DEPTH = 8
) ();

  logic                        in_valid;
  logic [2:0]                  in_cyctype;
  logic                        in_dir;
  logic [31:0]                 in_addr;
  logic [7:0]                  in_data;
  logic                        uart_ready;
  logic [7:0]                  out_data;
  logic                        out_latch;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [7:0]                  overflow_count;

  // Environment side: capture logic plus UART transmitter.
  modport master (
    output in_valid, in_cyctype, in_dir, in_addr, in_data, uart_ready,
    input  out_data, out_latch, busy, fifo_level, overflow_count
  );

  // Framer side.
  modport slave (
    input  in_valid, in_cyctype, in_dir, in_addr, in_data, uart_ready,
    output out_data, out_latch, busy, fifo_level, overflow_count
  );

endinterface

// File: rtl/lpc_record_fifo.sv
// Synchronous record FIFO with first-word fall-through read data.
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module lpc_record_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = 44
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LevelFull);
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and occupancy; a concurrent push and pop leaves the level unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/lpc_uart_framer.sv
// Buffers LPC cycle records and serializes each one as a 7-byte UART frame.
module lpc_uart_framer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'h5A
) (
  input logic              clock,
  input logic              reset,
  lpc_uart_framer_if.slave bus
);

  import lpc_uart_framer_pkg::*;

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic            ready_meta_q, ready_s_q;
  logic [1:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  lpc_rec_t        shadow_q, shadow_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_latch_q, out_latch_d;
  logic            lost_q, lost_d;
  logic [7:0]      ovf_q, ovf_d;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  lpc_rec_t        fifo_wdata, fifo_rdata;
  logic [LvlW-1:0] fifo_level;
  logic            drop, hdr_load;

  assign fifo_wdata = '{cyctype: bus.in_cyctype, dir: bus.in_dir,
                        addr: bus.in_addr, data: bus.in_data};
  // The full flag is registered, so a pop in the same cycle cannot make room.
  assign drop      = bus.in_valid & fifo_full;
  assign fifo_push = bus.in_valid & ~fifo_full;

  lpc_record_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (RecW)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Two-flop synchronizer for the transmitter's ready, which is on another clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_meta_q <= 1'b0;
      ready_s_q    <= 1'b0;
    end else begin
      ready_meta_q <= bus.uart_ready;
      ready_s_q    <= ready_meta_q;
    end
  end

  // Frame sequencer: load byte, strobe it, then wait for the transmitter to take it.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_latch_d = out_latch_q;
    fifo_pop    = 1'b0;
    hdr_load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shadow_d = fifo_rdata;
          idx_d    = ByteSync;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (ready_s_q) begin
          out_data_d = frame_byte(shadow_q, lost_q, idx_q, SYNC_BYTE);
          hdr_load   = (idx_q == ByteHdr);
          state_d    = StStrobe;
        end
      end
      StStrobe: begin
        out_latch_d = 1'b1;
        state_d     = StWaitAck;
      end
      StWaitAck: begin
        out_latch_d = 1'b0;
        if (!ready_s_q) begin
          if (idx_q == ByteData) begin
            state_d = StIdle;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Drop bookkeeping; a drop wins over the header-load clear of the lost flag.
  always_comb begin
    lost_d = lost_q;
    ovf_d  = ovf_q;
    if (hdr_load) lost_d = 1'b0;
    if (drop) begin
      lost_d = 1'b1;
      if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end
  end

  // Framer state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      shadow_q    <= '0;
      out_data_q  <= 8'h00;
      out_latch_q <= 1'b0;
      lost_q      <= 1'b0;
      ovf_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_latch_q <= out_latch_d;
      lost_q      <= lost_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_data       = out_data_q;
  assign bus.out_latch      = out_latch_q;
  assign bus.busy           = ~fifo_empty | (state_q != StIdle);
  assign bus.fifo_level     = fifo_level;
  assign bus.overflow_count = ovf_q;

endmodule
